dw_mult_pipe_hs: RTL and testbench

//  Parametrised N-stage pipelined multiplier; successor to the fixed 2-stage multiplier.

---
 rtl/dw_mult_pipe_hs.sv | 81 ++++++++
 tb/tb_dw_mult_pipe_hs.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_mult_pipe_hs.sv
// N-stage pipelined multiplier with a valid/ready handshake, per-operation signed/unsigned mode,
// a sideband tag and a synchronous flush. Each stage collapses bubbles independently.
module dw_mult_pipe_hs #(
    parameter int A_width    = 8,
    parameter int B_width    = 8,
    parameter int NUM_STAGES = 2,
    parameter int TAG_width  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FLUSH,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_width-1:0]         A,
    input  logic [B_width-1:0]         B,
    input  logic                       TC,
    input  logic [TAG_width-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [A_width+B_width-1:0] PRODUCT,
    output logic [TAG_width-1:0]       out_tag
);
    localparam int P_W = A_width + B_width;

    logic [P_W-1:0] w_a_ext;
    logic [P_W-1:0] w_b_ext;
    logic [P_W-1:0] w_prod_in;

    // Extending both operands to the full product width makes the truncated
    // product correct for both the unsigned and the two's complement case.
    assign w_a_ext   = {{B_width{TC & A[A_width-1]}}, A};
    assign w_b_ext   = {{A_width{TC & B[B_width-1]}}, B};
    assign w_prod_in = w_a_ext * w_b_ext;

    // Index 0 is the input port; index k is the content of stage k.
    logic [NUM_STAGES:0]  w_valid;
    logic [NUM_STAGES:1]  w_rdy;
    logic [P_W-1:0]       w_prod [0:NUM_STAGES];
    logic [TAG_width-1:0] w_tag  [0:NUM_STAGES];

    assign w_valid[0] = in_valid;
    assign w_prod[0]  = w_prod_in;
    assign w_tag[0]   = in_tag;

    genvar gi;
    generate
        for (gi = 1; gi <= NUM_STAGES; gi++) begin : g_stage
            logic                 r_valid;
            logic [P_W-1:0]       r_prod;
            logic [TAG_width-1:0] r_tag;

            // A stage can load when the output drains or any stage from here
            // to the output holds a bubble; flattened to avoid a ripple chain.
            assign w_rdy[gi] = out_ready | ~(&w_valid[NUM_STAGES:gi]);

            always_ff @(posedge CLK) begin
                if (RST || FLUSH) begin
                    r_valid <= 1'b0;
                    r_prod  <= '0;
                    r_tag   <= '0;
                end else if (w_rdy[gi]) begin
                    r_valid <= w_valid[gi-1];
                    if (w_valid[gi-1]) begin
                        r_prod <= w_prod[gi-1];
                        r_tag  <= w_tag[gi-1];
                    end
                end
            end

            assign w_valid[gi] = r_valid;
            assign w_prod[gi]  = r_prod;
            assign w_tag[gi]   = r_tag;
        end
    endgenerate

    assign in_ready  = w_rdy[1];
    assign out_valid = w_valid[NUM_STAGES];
    assign PRODUCT   = w_prod[NUM_STAGES];
    assign out_tag   = w_tag[NUM_STAGES];

endmodule

// File: tb/tb_dw_mult_pipe_hs.sv
// Bench for dw_mult_pipe_hs: directed handshake/arithmetic steps on a 2-stage 8x8 instance,
// then random traffic on 2-stage 8x8, 5-stage 12x5 and 1-stage 8x8 instances against a queue model.
module tb_dw_mult_pipe_hs;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, tc;
    logic [11:0] a;
    logic [7:0]  b;
    logic [3:0]  tag;
    int          sel;

    logic        rdy0, ov0, rdy1, ov1, rdy2, ov2;
    logic [15:0] prod0, prod2;
    logic [16:0] prod1;
    logic [3:0]  tag0, tag1, tag2;

    logic        rdy_s, ov_s;
    logic [31:0] prod_s;
    logic [3:0]  tag_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] p;
        logic [3:0]  t;
    } op_t;
    op_t q[$];

    always #5 clk = ~clk;

    dw_mult_pipe_hs #(.A_width(8), .B_width(8), .NUM_STAGES(2), .TAG_width(4)) u_dut0 (
        .CLK(clk), .RST(rst), .FLUSH(flush && sel == 0),
        .in_valid(in_valid && sel == 0), .in_ready(rdy0),
        .A(a[7:0]), .B(b[7:0]), .TC(tc), .in_tag(tag),
        .out_valid(ov0), .out_ready(out_ready && sel == 0),
        .PRODUCT(prod0), .out_tag(tag0)
    );

    dw_mult_pipe_hs #(.A_width(12), .B_width(5), .NUM_STAGES(5), .TAG_width(4)) u_dut1 (
        .CLK(clk), .RST(rst), .FLUSH(flush && sel == 1),
        .in_valid(in_valid && sel == 1), .in_ready(rdy1),
        .A(a), .B(b[4:0]), .TC(tc), .in_tag(tag),
        .out_valid(ov1), .out_ready(out_ready && sel == 1),
        .PRODUCT(prod1), .out_tag(tag1)
    );

    dw_mult_pipe_hs #(.A_width(8), .B_width(8), .NUM_STAGES(1), .TAG_width(4)) u_dut2 (
        .CLK(clk), .RST(rst), .FLUSH(flush && sel == 2),
        .in_valid(in_valid && sel == 2), .in_ready(rdy2),
        .A(a[7:0]), .B(b[7:0]), .TC(tc), .in_tag(tag),
        .out_valid(ov2), .out_ready(out_ready && sel == 2),
        .PRODUCT(prod2), .out_tag(tag2)
    );

    always_comb begin
        rdy_s  = rdy0;
        ov_s   = ov0;
        prod_s = 32'(prod0);
        tag_s  = tag0;
        if (sel == 1) begin
            rdy_s  = rdy1;
            ov_s   = ov1;
            prod_s = 32'(prod1);
            tag_s  = tag1;
        end else if (sel == 2) begin
            rdy_s  = rdy2;
            ov_s   = ov2;
            prod_s = 32'(prod2);
            tag_s  = tag2;
        end
    end

    function automatic int cfg_n(input int s);
        return (s == 0) ? 2 : (s == 1) ? 5 : 1;
    endfunction
    function automatic int cfg_aw(input int s);
        return (s == 1) ? 12 : 8;
    endfunction
    function automatic int cfg_bw(input int s);
        return (s == 1) ? 5 : 8;
    endfunction

    // Reference product from the arithmetic rules: interpret, multiply, wrap.
    function automatic logic [31:0] ref_prod(input logic [11:0] av, input logic [7:0] bv,
                                             input logic t, input int aw, input int bw);
        longint sa, sb, p, m;
        sa = longint'(av) & ((longint'(1) << aw) - 1);
        sb = longint'(bv) & ((longint'(1) << bw) - 1);
        if (t && sa[aw-1]) sa = sa - (longint'(1) << aw);
        if (t && sb[bw-1]) sb = sb - (longint'(1) << bw);
        p = sa * sb;
        m = (longint'(1) << (aw + bw)) - 1;
        return 32'(p & m);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] av, input logic [7:0] bv,
                         input logic t, input logic [3:0] g);
        in_valid = v;
        a        = av;
        b        = bv;
        tc       = t;
        tag      = g;
    endtask

    task automatic rnd_cycle(input bit allow_in);
        logic fl;
        int   n;
        op_t  e;
        n         = cfg_n(sel);
        fl        = allow_in && ($urandom_range(0, 39) == 0);
        flush     = fl;
        in_valid  = allow_in && ($urandom_range(0, 2) != 0);
        out_ready = allow_in ? ($urandom_range(0, 3) != 0) : 1'b1;
        a         = 12'($urandom);
        b         = 8'($urandom);
        tc        = 1'($urandom);
        tag       = 4'($urandom);
        #1;
        check("rnd_in_ready", 32'(rdy_s), 32'((q.size() < n) || out_ready));
        if (q.size() == 0) check("rnd_valid_when_empty", 32'(ov_s), 32'd0);
        if (fl) begin
            q.delete();
        end else begin
            if (ov_s && out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("rnd_product", prod_s, e.p);
                check("rnd_tag", 32'(tag_s), 32'(e.t));
            end
            if (in_valid && rdy_s) begin
                e.p = ref_prod(a, b, tc, cfg_aw(sel), cfg_bw(sel));
                e.t = tag;
                q.push_back(e);
            end
        end
        tick();
        if (fl) begin
            check("rnd_flush_valid", 32'(ov_s), 32'd0);
            check("rnd_flush_product", prod_s, 32'd0);
        end
    endtask

    initial begin
        int acc;
        sel = 0; rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 12'h0, 8'h0, 1'b0, 4'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(ov_s), 32'd0);
        check("reset_product", prod_s, 32'd0);
        check("reset_tag", 32'(tag_s), 32'd0);
        check("reset_in_ready", 32'(rdy_s), 32'd1);

        // Unsigned product with two-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 12'hFF, 8'h02, 1'b0, 4'd1);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
        check("lat_not_early", 32'(ov_s), 32'd0);
        tick();
        check("lat_valid", 32'(ov_s), 32'd1);
        check("unsigned_ff_x_02", prod_s, 32'h01FE);
        check("unsigned_tag", 32'(tag_s), 32'd1);
        tick();
        check("idle_valid_low", 32'(ov_s), 32'd0);
        check("idle_product_held", prod_s, 32'h01FE);

        // Signed products, back to back
        drive(1'b1, 12'hFF, 8'h02, 1'b1, 4'd2);
        tick();
        drive(1'b1, 12'h80, 8'h80, 1'b1, 4'd3);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
        check("signed_ff_x_02", prod_s, 32'hFFFE);
        check("signed_tag2", 32'(tag_s), 32'd2);
        tick();
        check("signed_80_x_80", prod_s, 32'h4000);
        check("signed_tag3", 32'(tag_s), 32'd3);
        tick();

        // Six-operation stream at full throughput
        for (int t = 0; t < 8; t++) begin
            if (t < 6) drive(1'b1, 12'(t + 1), 8'd3, 1'b0, 4'(t));
            else       drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
            if (t < 6) check("stream_in_ready", 32'(rdy_s), 32'd1);
            tick();
            check("stream_out_valid", 32'(ov_s), 32'((t >= 1) && (t <= 6)));
            if (t >= 1 && t <= 6) begin
                check("stream_tag", 32'(tag_s), 32'(t - 1));
                check("stream_product", prod_s, 32'(t * 3));
            end
        end

        // Full backpressure: only NUM_STAGES operations fit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 12'(8 + acc), 8'd5, 1'b0, 4'(8 + acc));
            #1;
            if (rdy_s) acc++;
            tick();
        end
        check("stall_accept_count", 32'(acc), 32'd2);
        check("stall_in_ready", 32'(rdy_s), 32'd0);
        check("stall_head_tag", 32'(tag_s), 32'd8);
        tick(); tick();
        check("stall_product_stable", prod_s, 32'd40);
        check("stall_tag_stable", 32'(tag_s), 32'd8);
        drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
        out_ready = 1'b1;
        #1;
        check("drain_first_tag", 32'(tag_s), 32'd8);
        tick();
        check("drain_second_valid", 32'(ov_s), 32'd1);
        check("drain_second_tag", 32'(tag_s), 32'd9);
        check("drain_second_product", prod_s, 32'd45);
        tick();
        check("drain_empty", 32'(ov_s), 32'd0);

        // Bubble collapse behind a stalled final stage
        out_ready = 1'b0;
        drive(1'b1, 12'd7, 8'd7, 1'b0, 4'd4);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
        tick();
        check("bubble_head_valid", 32'(ov_s), 32'd1);
        check("bubble_in_ready", 32'(rdy_s), 32'd1);
        drive(1'b1, 12'd2, 8'd3, 1'b0, 4'd5);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
        check("bubble_full_in_ready", 32'(rdy_s), 32'd0);
        check("bubble_head_tag", 32'(tag_s), 32'd4);
        check("bubble_head_product", prod_s, 32'd49);
        out_ready = 1'b1;
        tick();
        check("bubble_next_tag", 32'(tag_s), 32'd5);
        check("bubble_next_product", prod_s, 32'd6);
        tick();
        check("bubble_drained", 32'(ov_s), 32'd0);

        // FLUSH (pass 0) and RST (pass 1) with two ops in flight and a concurrent input
        for (int pass = 0; pass < 2; pass++) begin
            out_ready = 1'b0;
            drive(1'b1, 12'd3, 8'd3, 1'b0, 4'd6);
            tick();
            drive(1'b1, 12'd4, 8'd4, 1'b0, 4'd7);
            tick();
            check("clear_pre_tag", 32'(tag_s), 32'd6);
            if (pass == 0) flush = 1'b1;
            else           rst = 1'b1;
            drive(1'b1, 12'd5, 8'd5, 1'b0, 4'd8);
            tick();
            flush = 1'b0;
            rst   = 1'b0;
            drive(1'b0, 12'h0, 8'h0, 1'b0, 4'd0);
            check("clear_out_valid", 32'(ov_s), 32'd0);
            check("clear_product", prod_s, 32'd0);
            check("clear_tag", 32'(tag_s), 32'd0);
            check("clear_in_ready", 32'(rdy_s), 32'd1);
            out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("clear_no_ghost", 32'(ov_s), 32'd0);
            end
        end

        // Random traffic on each configuration
        for (int s = 0; s < 3; s++) begin
            sel = s;
            q.delete();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            for (int c = 0; c < 400; c++) rnd_cycle(1'b1);
            for (int c = 0; c < cfg_n(s) + 3; c++) rnd_cycle(1'b0);
            check("rnd_all_drained", 32'(q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
